// File: rtl/nec_ir_rx_frame.sv
// NEC IR frame receiver: measures leader, bit and stop timing on the synchronised pin,
// validates the decoded word and hands it to control logic via a valid/ack handshake.
`timescale 1ns/1ps
module nec_ir_rx_frame #(
    parameter int SYNC_STAGES = 2,
    parameter int LEAD_LO_MIN = 155,
    parameter int LEAD_LO_MAX = 165,
    parameter int LEAD_HI_MIN = 75,
    parameter int LEAD_HI_MAX = 85,
    parameter int RPT_HI_MIN  = 35,
    parameter int RPT_HI_MAX  = 45,
    parameter int BIT_ONE_MIN = 20,
    parameter int BIT_MAX     = 35,
    parameter int FRAME_MAX   = 1280,
    parameter bit CHECK_CMD   = 1'b1,
    parameter bit CHECK_ADDR  = 1'b0
) (
    input  logic        nec_clk,
    input  logic        reset_n,
    input  logic        ir_signal,
    input  logic        ack,
    output logic [31:0] word,
    output logic [15:0] addr,
    output logic [7:0]  cmd,
    output logic        valid,
    output logic        rpt,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        busy
);
    localparam int CW = $clog2(FRAME_MAX + 1);

    typedef enum logic [2:0] {IDLE, LEAD_LO, LEAD_HI, BITS, STOP, RPT_STOP} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_prev_q;
    logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
    logic [CW-1:0]          frame_q, frame_d, frame_inc;
    logic [5:0]             bit_cnt_q, bit_cnt_d;
    logic [31:0]            shift_q, shift_d;
    logic [31:0]            word_q, word_d;
    logic                   valid_q, valid_d;
    logic                   rpt_q, rpt_d;
    logic                   err_q, err_d;
    logic [1:0]             err_code_q, err_code_d;
    logic                   have_q, have_d;

    logic s, fall, rise;
    logic timing_err, check_fail, accept, rpt_hit, checks_ok;

    assign s         = sync_q[SYNC_STAGES-1];
    assign fall      = s_prev_q & ~s;
    assign rise      = ~s_prev_q & s;
    assign cnt_inc   = (&cnt_q)   ? cnt_q   : cnt_q + CW'(1);
    assign frame_inc = (&frame_q) ? frame_q : frame_q + CW'(1);
    assign checks_ok = (!CHECK_CMD  || ((shift_q[15:8]  ^ shift_q[7:0])   == 8'hFF)) &&
                       (!CHECK_ADDR || ((shift_q[31:24] ^ shift_q[23:16]) == 8'hFF));

    // NOTE: synchroniser flops reset to 1 (idle level) so leaving reset never looks like a falling edge.
    always_ff @(posedge nec_clk) begin
        if (!reset_n) begin
            sync_q   <= '1;
            s_prev_q <= 1'b1;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], ir_signal};
            s_prev_q <= s;
        end
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge nec_clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            frame_q    <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            word_q     <= '0;
            valid_q    <= 1'b0;
            rpt_q      <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
            have_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            frame_q    <= frame_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            word_q     <= word_d;
            valid_q    <= valid_d;
            rpt_q      <= rpt_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            have_q     <= have_d;
        end
    end

    // NOTE: every variable gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_inc;
        frame_d    = frame_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        timing_err = 1'b0;
        check_fail = 1'b0;
        accept     = 1'b0;
        rpt_hit    = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fall) state_d = LEAD_LO;
            end
            LEAD_LO: begin
                if (rise) begin
                    if (int'(cnt_q) >= LEAD_LO_MIN && int'(cnt_q) <= LEAD_LO_MAX) begin
                        state_d = LEAD_HI;
                        cnt_d   = '0;
                    end else timing_err = 1'b1;
                end else if (int'(cnt_q) > LEAD_LO_MAX) timing_err = 1'b1;
            end
            LEAD_HI: begin
                if (fall) begin
                    cnt_d = '0;
                    if (int'(cnt_q) >= LEAD_HI_MIN && int'(cnt_q) <= LEAD_HI_MAX) begin
                        state_d   = BITS;
                        frame_d   = '0;
                        bit_cnt_d = '0;
                    end else if (int'(cnt_q) >= RPT_HI_MIN && int'(cnt_q) <= RPT_HI_MAX) begin
                        state_d = RPT_STOP;
                    end else timing_err = 1'b1;
                end else if (int'(cnt_q) > LEAD_HI_MAX) timing_err = 1'b1;
            end
            BITS: begin
                frame_d = frame_inc;
                if (int'(cnt_q) > BIT_MAX || int'(frame_q) > FRAME_MAX) begin
                    timing_err = 1'b1;
                end else if (rise) begin
                    cnt_d = '0;
                end else if (fall) begin
                    // A falling edge closes a space; its length decides the bit value.
                    cnt_d     = '0;
                    shift_d   = {shift_q[30:0], int'(cnt_q) >= BIT_ONE_MIN};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    if (bit_cnt_q == 6'd31) state_d = STOP;
                end
            end
            STOP: begin
                frame_d = frame_inc;
                if (int'(cnt_q) > BIT_MAX || int'(frame_q) > FRAME_MAX) begin
                    timing_err = 1'b1;
                end else if (rise) begin
                    accept     = checks_ok;
                    check_fail = !checks_ok;
                    state_d    = IDLE;
                end
            end
            RPT_STOP: begin
                if (int'(cnt_q) > BIT_MAX) begin
                    timing_err = 1'b1;
                end else if (rise) begin
                    rpt_hit = have_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (timing_err) begin
            state_d = IDLE;
            shift_d = '0;
        end
    end

    always_comb begin
        word_d     = word_q;
        valid_d    = valid_q;
        have_d     = have_q;
        rpt_d      = rpt_hit;
        err_d      = 1'b0;
        err_code_d = err_code_q;

        if (valid_q && ack) valid_d = 1'b0;

        if (accept) begin
            // An unconsumed word is protected unless the consumer acks in this very cycle.
            if (valid_q && !ack) begin
                err_d      = 1'b1;
                err_code_d = 2'd3;
            end else begin
                word_d  = shift_q;
                valid_d = 1'b1;
                have_d  = 1'b1;
            end
        end else if (check_fail) begin
            err_d      = 1'b1;
            err_code_d = 2'd2;
        end else if (timing_err) begin
            err_d      = 1'b1;
            err_code_d = 2'd1;
        end
    end

    assign word     = word_q;
    assign addr     = word_q[31:16];
    assign cmd      = word_q[15:8];
    assign valid    = valid_q;
    assign rpt      = rpt_q;
    assign err      = err_q;
    assign err_code = err_code_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_nec_ir_rx_frame.sv
// Self-checking bench for nec_ir_rx_frame: directed scenarios plus randomized frames
// scored against a transaction-level model of the receiver's outcomes.
`timescale 1ns/1ps
module tb_nec_ir_rx_frame;
    logic        nec_clk   = 1'b0;
    logic        reset_n   = 1'b0;
    logic        ir_signal = 1'b1;
    logic        ack       = 1'b0;
    logic [31:0] word;
    logic [15:0] addr;
    logic [7:0]  cmd;
    logic        valid, rpt, err, busy;
    logic [1:0]  err_code;

    always #5 nec_clk = ~nec_clk;

    nec_ir_rx_frame dut (
        .nec_clk  (nec_clk),
        .reset_n  (reset_n),
        .ir_signal(ir_signal),
        .ack      (ack),
        .word     (word),
        .addr     (addr),
        .cmd      (cmd),
        .valid    (valid),
        .rpt      (rpt),
        .err      (err),
        .err_code (err_code),
        .busy     (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int err_seen = 0;
    int rpt_seen = 0;

    // Reference model state: what the consumer should observe.
    logic [31:0] m_word  = '0;
    logic        m_valid = 1'b0;
    logic        m_have  = 1'b0;
    logic [1:0]  m_code  = 2'd0;
    int          m_err   = 0;
    int          m_rpt   = 0;

    always @(negedge nec_clk) begin
        if (err) err_seen++;
        if (rpt) rpt_seen++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached (got=timeout exp=finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic seg(input logic lvl, input int n);
        ir_signal = lvl;
        repeat (n) @(negedge nec_clk);
    endtask

    task automatic idle(input int n);
        seg(1'b1, n);
    endtask

    // Sends leader + nbits of w; with nbits == 32 also the stop mark and its release.
    task automatic send_frame(input logic [31:0] w, input int one_len, input int nbits,
                              input bit ack_acc, input bit chk_lat);
        seg(1'b0, 160);
        seg(1'b1, 80);
        for (int i = 31; i > 31 - nbits; i--) begin
            seg(1'b0, 10);
            seg(1'b1, w[i] ? one_len : 10);
        end
        if (nbits == 32) begin
            seg(1'b0, 10);
            ir_signal = 1'b1;
            @(negedge nec_clk);
            @(negedge nec_clk);
            if (chk_lat) check("lat_before_accept", valid, 0);
            if (ack_acc) ack = 1'b1;
            @(negedge nec_clk);
            ack = 1'b0;
            if (chk_lat) check("lat_at_accept", valid, 1);
        end
    endtask

    task automatic send_rpt();
        seg(1'b0, 160);
        seg(1'b1, 40);
        seg(1'b0, 10);
        ir_signal = 1'b1;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(negedge nec_clk);
        ack = 1'b0;
        m_valid = 1'b0;
        check("ack_clears_valid", valid, 0);
    endtask

    // Outcome of a complete, well-timed frame.
    task automatic m_frame(input logic [31:0] w, input bit ack_acc);
        if ((w[15:8] ^ w[7:0]) != 8'hFF) begin
            m_err++;
            m_code = 2'd2;
            if (ack_acc) m_valid = 1'b0;
        end else if (m_valid && !ack_acc) begin
            m_err++;
            m_code = 2'd3;
        end else begin
            m_word  = w;
            m_valid = 1'b1;
            m_have  = 1'b1;
        end
    endtask

    task automatic m_timing_err();
        m_err++;
        m_code = 2'd1;
    endtask

    task automatic m_repeat();
        if (m_have) m_rpt++;
    endtask

    task automatic m_reset();
        m_word  = '0;
        m_valid = 1'b0;
        m_have  = 1'b0;
        m_code  = 2'd0;
    endtask

    task automatic verify(input string tag);
        check({tag, ".err_count"}, err_seen, m_err);
        check({tag, ".rpt_count"}, rpt_seen, m_rpt);
        check({tag, ".err_code"}, err_code, m_code);
        check({tag, ".valid"}, valid, m_valid);
        check({tag, ".word"}, word, m_word);
        check({tag, ".addr"}, addr, m_word[31:16]);
        check({tag, ".cmd"}, cmd, m_word[15:8]);
        check({tag, ".busy"}, busy, 0);
    endtask

    function automatic logic [31:0] good_word();
        logic [15:0] a;
        logic [7:0]  c;
        a = 16'($urandom);
        c = 8'($urandom);
        return {a, c, ~c};
    endfunction

    initial begin
        logic [31:0] w;
        int kind;

        repeat (4) @(negedge nec_clk);
        verify("reset");
        check("reset.rpt", rpt, 0);
        check("reset.err", err, 0);
        reset_n = 1'b1;
        idle(10);

        // Repeat code with no frame accepted yet: silent.
        send_rpt();
        idle(60);
        verify("rpt_no_frame");

        // Known key frame with accept latency.
        send_frame(32'h20DF6A95, 30, 32, 1'b0, 1'b1);
        m_frame(32'h20DF6A95, 1'b0);
        idle(60);
        verify("frame_up");

        send_rpt();
        m_repeat();
        idle(60);
        verify("rpt_after_frame");

        do_ack();
        send_frame(32'h20DF6A94, 30, 32, 1'b0, 1'b0);
        m_frame(32'h20DF6A94, 1'b0);
        idle(60);
        verify("cmd_check_fail");

        // Overrun, then accept with simultaneous ack.
        w = good_word();
        send_frame(w, 30, 32, 1'b0, 1'b0);
        m_frame(w, 1'b0);
        idle(60);
        verify("first_of_two");
        w = good_word();
        send_frame(w, 30, 32, 1'b0, 1'b0);
        m_frame(w, 1'b0);
        idle(60);
        verify("overrun");
        w = good_word();
        send_frame(w, 30, 32, 1'b1, 1'b0);
        m_frame(w, 1'b1);
        idle(60);
        verify("ack_on_accept");

        do_ack();
        seg(1'b0, 170);
        m_timing_err();
        idle(60);
        verify("long_leader");

        send_frame(32'h20DF6A95, 30, 5, 1'b0, 1'b0);
        seg(1'b0, 10);
        seg(1'b1, 40);
        m_timing_err();
        idle(60);
        verify("long_space");

        // Reset in the middle of bit 17.
        send_frame(32'h20DF6A95, 30, 17, 1'b0, 1'b0);
        reset_n = 1'b0;
        @(negedge nec_clk);
        reset_n = 1'b1;
        m_reset();
        verify("mid_frame_reset");
        idle(60);
        send_frame(32'h20DF6A95, 30, 32, 1'b0, 1'b0);
        m_frame(32'h20DF6A95, 1'b0);
        idle(60);
        verify("after_reset");

        for (int k = 0; k < 12; k++) begin
            kind = int'($urandom_range(0, 4));
            if ($urandom_range(0, 1) == 1) do_ack();
            w = good_word();
            unique case (kind)
                0: begin
                    send_frame(w, 25, 32, 1'b0, 1'b0);
                    m_frame(w, 1'b0);
                end
                1: begin
                    w[7:0] = w[7:0] ^ (8'h01 << $urandom_range(0, 7));
                    send_frame(w, 25, 32, 1'b0, 1'b0);
                    m_frame(w, 1'b0);
                end
                2: begin
                    send_rpt();
                    m_repeat();
                end
                3: begin
                    send_frame(w, 25, 32, 1'b1, 1'b0);
                    m_frame(w, 1'b1);
                end
                default: begin
                    send_frame(w, 25, int'($urandom_range(1, 31)), 1'b0, 1'b0);
                    m_timing_err();
                end
            endcase
            idle(60);
            verify($sformatf("rand%0d_k%0d", k, kind));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
